et_sng: RTL and testbench
=========================

// Module: et_sng
// PURPOSE
// - Early-termination stochastic number generator: binary-to-stochastic converter for the ET datapath.
// - Accepts a WIDTH-bit unsigned fraction Bx and emits a unipolar bitstream px of 2^prec bits.
// - Each bit is (bit_reverse(ctr) < Bx), so every power-of-two-length prefix encodes Bx at that precision.
// - px_seg marks the power-of-two boundaries on which the progressive SBC receiver halves and accumulates.
// PARAMETERS
// - WIDTH   8                    value width; full stream length is 2^WIDTH
// - PREC_W  $clog2(WIDTH+1)      width of the prec input
// PORTS
// - clk       in   1        clock
// - rst_n     in   1        synchronous active-low reset
// - in_valid  in   1        Bx/prec offered
// - in_ready  out  1        block can accept a new value
// - Bx        in   WIDTH    fraction; LSB weight 2^-WIDTH
// - prec      in   PREC_W   stream length is 2^prec; values above WIDTH clamp to WIDTH
// - stop      in   1        early termination: abandon the current stream
// - px_valid  out  1        px beat valid
// - px_ready  in   1        consumer accepts the beat
// - px        out  1        stochastic bit
// - px_seg    out  1        beat index+1 is a power of two (index 0,1,3,7,...)
// - px_last   out  1        final beat of the stream
// BEHAVIOUR
// - One clock, clk. Synchronous active-low reset rst_n.
// - Reset state:
//   - state=IDLE, ctr=0, bx_q=0, len_q=0.
//   - Outputs: in_ready=1, px_valid=0, px=0, px_seg=0, px_last=0.
//   - Reset asserted mid-stream discards the stream; no px_last is produced.
// - FSM IDLE:
//   - in_ready=1, px_valid=0.
//   - On in_valid: latch bx_q=Bx, len_q=2^min(prec,WIDTH)-1 (WIDTH+1 bits), ctr=0, go RUN.
// - FSM RUN:
//   - in_ready=0, px_valid=1.
//   - px=(rev(ctr[WIDTH-1:0]) < bx_q), where rev maps bit i to bit WIDTH-1-i.
//   - px_seg=((ctr+1)&ctr)==0.
//   - px_last=(ctr==len_q).
// - Handshake (px_valid & px_ready):
//   - ctr advances by 1.
//   - If px_last is also high, go IDLE; no further beat follows.
// - Stall: while px_ready=0, px/px_seg/px_last/ctr hold stable. Outputs depend only on registers (no comb path px_ready->px).
// - stop in RUN:
//   - Go IDLE next cycle. A beat handshaken in the same cycle counts as delivered.
//   - No px_last is emitted for a stopped stream.
//   - stop is ignored in IDLE.
// - Latency: first beat is valid the cycle after the input handshake. A new input is accepted the cycle after the final beat or stop (stream-to-stream gap of 1 cycle).
// - Ones count after 2^k beats = ceil(Bx / 2^(WIDTH-k)), exact at k=WIDTH.
// - Boundaries:
//   - prec=0 gives 1 beat: px=(Bx!=0), px_seg=1, px_last=1.
//   - Bx=0 gives all zeros.
//   - Bx=2^WIDTH-1 at full precision gives 2^WIDTH-1 ones.
//   - ctr is WIDTH+1 bits so len_q=2^WIDTH-1 terminates without wrap.
// - Inputs Bx/prec are sampled only at the IDLE handshake; changes during RUN have no effect.
// STRUCTURE
// - sc_pkg: state enum {IDLE,RUN}, function bit_rev(WIDTH), function is_pow2_m1.
// - Sub-module rev_ctr:
//   - Ports: clear, enable, len_q compare.
//   - Outputs: reversed count, seg flag, last flag.
//   - Instantiated once. Top level holds the FSM, bx_q and the comparator.
// TESTING
// - WIDTH=4, Bx=10, prec=4, px_ready=1 -> 16 beats, 10 ones, px_last on beat 15, px_seg on beats 0,1,3,7,15.
// - WIDTH=4, Bx=10, prec=2 -> px=1,1,1,0; px_last on beat 3; in_ready=1 the next cycle.
// - Random px_ready stalls, Bx=5, prec=4 -> beat sequence identical to the unstalled run; outputs stable during stalls.
// - stop on beat 5 of a prec=4 stream -> px_valid=0 next cycle, no px_last, new input accepted the following cycle.
// - Edge values: prec=0 with Bx=0 -> one beat px=0; prec=0 with Bx=1 -> one beat px=1; prec=7 with WIDTH=4 -> clamps to 16 beats.
// - rst_n=0 mid-stream -> all outputs at reset values next cycle; back-to-back streams via the et_sbc receiver recover Bx at each px_seg.

Source files
------------

// File: rtl/et_sng_pkg.sv
// Shared types and helpers for the early-termination stochastic number generator.
// Holds the FSM state encoding plus the bit-reversal and boundary-detect helpers.
package et_sng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reverse the low w bits of v; bits at or above w come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(w)) begin
                r[int'(w) - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

    // True when v+1 is a power of two (v = 0, 1, 3, 7, ...).
    function automatic logic is_pow2_m1(input logic [31:0] v);
        return ((v + 32'd1) & v) == 32'd0;
    endfunction

endpackage

// File: rtl/et_sng_rev_ctr.sv
// Beat counter for the SNG: exposes the bit-reversed low count, the power-of-two
// segment flag and the end-of-stream flag against the latched stream length.
module et_sng_rev_ctr
    import et_sng_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH:0]   len_q,
    output logic [WIDTH-1:0] rev_cnt,
    output logic             seg,
    output logic             last
);

    // One bit wider than the value so a full 2^WIDTH-beat stream ends without wrap.
    logic [WIDTH:0] ctr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ctr_reg <= '0;
        end else if (enable) begin
            ctr_reg <= ctr_reg + (WIDTH+1)'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign rev_cnt[gi] = ctr_reg[WIDTH-1-gi];
        end
    endgenerate

    assign seg  = is_pow2_m1(32'(ctr_reg));
    assign last = (ctr_reg == len_q);

endmodule

// File: rtl/et_sng.sv
// Early-termination stochastic number generator: turns an unsigned fraction Bx into a
// unipolar bitstream whose every power-of-two prefix encodes Bx at that precision.
module et_sng
    import et_sng_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PREC_W = $clog2(WIDTH+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  Bx,
    input  logic [PREC_W-1:0] prec,
    input  logic              stop,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px,
    output logic              px_seg,
    output logic              px_last
);

    state_t            state_reg;
    logic [WIDTH-1:0]  bx_q;
    logic [WIDTH:0]    len_q;

    logic [PREC_W-1:0] prec_c;
    logic [WIDTH:0]    len_next;
    logic [WIDTH-1:0]  rev_cnt;
    logic              seg;
    logic              last;
    logic              fire;
    logic              running;

    assign prec_c   = (int'(prec) > WIDTH) ? PREC_W'(WIDTH) : prec;
    assign len_next = ((WIDTH+1)'(1) << prec_c) - (WIDTH+1)'(1);

    assign running = (state_reg == RUN);
    assign fire    = running && px_ready;

    et_sng_rev_ctr #(
        .WIDTH (WIDTH)
    ) u_rev_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!running),
        .enable  (fire),
        .len_q   (len_q),
        .rev_cnt (rev_cnt),
        .seg     (seg),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bx_q      <= '0;
            len_q     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        bx_q      <= Bx;
                        len_q     <= len_next;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // A beat handshaken alongside stop still counts as delivered.
                    if (stop || (fire && last)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only, so px_ready never reaches px.
    assign in_ready = !running;
    assign px_valid = running;
    assign px       = running && (rev_cnt < bx_q);
    assign px_seg   = running && seg;
    assign px_last  = running && last;

endmodule

// File: tb/tb_et_sng.sv
// Scoreboard bench for et_sng at WIDTH=4: directed streams push expected beats,
// a negedge monitor pops and compares each handshaken beat.
module tb_et_sng;

    localparam int WIDTH  = 4;
    localparam int PREC_W = $clog2(WIDTH+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  bx = '0;
    logic [PREC_W-1:0] prec = '0;
    logic              stop = 1'b0;
    logic              px_valid;
    logic              px_ready = 1'b0;
    logic              px;
    logic              px_seg;
    logic              px_last;

    et_sng #(
        .WIDTH  (WIDTH),
        .PREC_W (PREC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Bx       (bx),
        .prec     (prec),
        .stop     (stop),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px       (px),
        .px_seg   (px_seg),
        .px_last  (px_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic px;
        logic seg;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every handshaken beat and checks outputs hold across stalls.
    beat_t mon_e;
    beat_t held;
    logic  held_ok = 1'b0;

    always @(negedge clk) begin
        if (rst_n && px_valid) begin
            if (held_ok) begin
                check("stall_hold", 32'({px, px_seg, px_last}), 32'(held));
            end
            if (px_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("px", 32'(px), 32'(mon_e.px));
                    check("px_seg", 32'(px_seg), 32'(mon_e.seg));
                    check("px_last", 32'(px_last), 32'(mon_e.last));
                end
                held_ok = 1'b0;
            end else begin
                held    = {px, px_seg, px_last};
                held_ok = 1'b1;
            end
        end else begin
            held_ok = 1'b0;
        end
    end

    task automatic check_idle(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_px_valid"}, 32'(px_valid), 32'd0);
        check({name, "_px"}, 32'(px), 32'd0);
        check({name, "_px_seg"}, 32'(px_seg), 32'd0);
        check({name, "_px_last"}, 32'(px_last), 32'd0);
    endtask

    // pat bit i = expected px of beat i. stop_at / rst_at < 0 disable those events.
    task automatic run_stream(input string tag, input logic [WIDTH-1:0] b,
                              input logic [PREC_W-1:0] p, input int nb,
                              input logic [15:0] pat, input int stop_at,
                              input bit stall, input int rst_at);
        logic [15:0] seg_mask;
        int   n_exp;
        int   beat;
        int   cyc;
        int   t;
        bit   done;
        bit   fire;
        bit   lastb;
        seg_mask = 16'h808B;
        n_exp = 0;
        for (int i = 0; i < nb; i++) begin
            if (stop_at >= 0 && i > stop_at) break;
            if (rst_at >= 0 && i >= rst_at) break;
            exp_q.push_back({pat[i], seg_mask[i], (i == nb-1) && stop_at < 0 && rst_at < 0});
            n_exp++;
        end
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; bx = b; prec = p;
        @(posedge clk); #1;
        // Scramble inputs: they must be ignored once the stream is running.
        in_valid = 1'b0; bx = ~b; prec = PREC_W'(1);
        check({tag, "_first_valid"}, 32'(px_valid), 32'd1);
        beat = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            if (rst_at >= 0 && beat == rst_at) begin
                px_ready = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_idle({tag, "_rst"});
                done = 1'b1;
            end else begin
                px_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                fire  = px_valid && px_ready;
                lastb = px_last;
                stop  = fire && (beat == stop_at);
                @(posedge clk); #1;
                stop = 1'b0;
                cyc++;
                if (fire) begin
                    if (lastb || beat == stop_at) done = 1'b1;
                    beat++;
                end
            end
        end
        px_ready = 1'b0;
        check({tag, "_no_timeout"}, 32'(done), 32'd1);
        check({tag, "_beats"}, 32'(beat), 32'(n_exp));
        check({tag, "_after_valid"}, 32'(px_valid), 32'd0);
        check({tag, "_after_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        $display("stream %s: Bx=%0d prec=%0d beats=%0d cycles=%0d", tag, b, p, beat, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        // stop has no effect while idle
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check_idle("stop_idle");

        run_stream("bx10_p4",   4'd10, 3'd4, 16, 16'h5757, -1, 1'b0, -1);
        run_stream("bx10_p2",   4'd10, 3'd2,  4, 16'h0007, -1, 1'b0, -1);
        run_stream("bx5_p4",    4'd5,  3'd4, 16, 16'h1115, -1, 1'b0, -1);
        run_stream("bx5_stall", 4'd5,  3'd4, 16, 16'h1115, -1, 1'b1, -1);
        run_stream("stop5",     4'd10, 3'd4, 16, 16'h5757,  5, 1'b0, -1);
        run_stream("bx0_p0",    4'd0,  3'd0,  1, 16'h0000, -1, 1'b0, -1);
        run_stream("bx1_p0",    4'd1,  3'd0,  1, 16'h0001, -1, 1'b0, -1);
        run_stream("bx0_p4",    4'd0,  3'd4, 16, 16'h0000, -1, 1'b0, -1);
        run_stream("bx15_p7",   4'd15, 3'd7, 16, 16'h7FFF, -1, 1'b0, -1);
        run_stream("rst_mid",   4'd10, 3'd4, 16, 16'h5757, -1, 1'b0,  3);
        run_stream("recover",   4'd5,  3'd3,  8, 16'h1115, -1, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
